ans_delay_generator: RTL and testbench
======================================

ANS_DELAY_GENERATOR -- requirements
Module: ans_delay_generator

Interface
REQ-001 SHALL have parameter GAP_TICKS, default 16'd35, inter-byte silence (ticks) declaring rx frame end.
REQ-002 SHALL have parameter MAX_DLY_TIME, default 16'd999, saturation limit for programmed delay.
REQ-003 SHALL have parameter MAX_WAIT, default 16'd9999, ticks allowed for response data after delay expiry.
REQ-004 clk  input  1  system clock, >=40MHz.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 p_sig_10MHz_i  input  1  one-clk time-base tick strobe.
REQ-007 p_DataReceived_i  input  1  one-clk pulse per byte received by rx core.
REQ-008 dly_set_i  input  16  programmed answer delay, ticks.
REQ-009 p_tx_ready_i  input  1  response data present in tx buffer (level).
REQ-010 p_SendFinished_i  input  1  one-clk pulse, tx core finished last byte stop bit.
REQ-011 n_clr_i  input  1  active-low synchronous abort/clear.
REQ-012 p_tx_start_o  output  1  one-clk pulse commanding tx core to start.
REQ-013 p_busy_o  output  1  high in any state except IDLE.
REQ-014 p_timeout_o  output  1  sticky: response data not ready within MAX_WAIT.
REQ-015 actual_dly_o  output  16  ticks from frame end to tx start, last response.

Function
REQ-016 States SHALL be IDLE, GAP, DELAY, WAIT_DATA, SEND; registered state, one-hot or binary free.
REQ-017 IDLE: p_DataReceived_i -> GAP, gap_cnt=0.
REQ-018 GAP: p_DataReceived_i -> gap_cnt=0, stay; else tick -> gap_cnt+1; tick with gap_cnt==GAP_TICKS-1 -> DELAY, dly_cnt=0, target latched = min(dly_set_i, MAX_DLY_TIME).
REQ-019 GAP: simultaneous tick and p_DataReceived_i SHALL clear gap_cnt (byte wins).
REQ-020 DELAY: tick -> dly_cnt+1; when dly_cnt>=target (checked every clk, so target 0 acts next clk): if p_tx_ready_i pulse p_tx_start_o, go SEND; else go WAIT_DATA.
REQ-021 DELAY: p_DataReceived_i (frame not over) -> GAP, gap_cnt=0, no start issued.
REQ-022 WAIT_DATA: dly_cnt keeps counting on ticks (saturating 16'hFFFF); p_tx_ready_i -> pulse p_tx_start_o, SEND; wait_cnt reaching MAX_WAIT on a tick -> p_timeout_o=1, IDLE; ready and limit same clk: ready wins.
REQ-023 On every p_tx_start_o pulse actual_dly_o SHALL load dly_cnt same edge (registered, visible next clk).
REQ-024 p_tx_start_o SHALL be exactly one clk wide, registered, asserted same edge as entry to SEND.
REQ-025 SEND: p_SendFinished_i -> IDLE; p_DataReceived_i ignored.
REQ-026 n_clr_i==0 SHALL override all: state IDLE, counters 0, p_timeout_o 0, p_tx_start_o 0; actual_dly_o retained.
REQ-027 All counters 16 bit, saturating, never wrapping.

Reset
REQ-028 On rst low: state IDLE, all counters 0, p_tx_start_o 0, p_busy_o 0, p_timeout_o 0, actual_dly_o 0.
REQ-029 Reset mid-operation SHALL abort with no start pulse; release synchronous to clk.

Structure
REQ-030 State encodings and GAP_TICKS/MAX_DLY_TIME/MAX_WAIT defaults SHALL live in shared uart package.
REQ-031 One sub-module natural: tick_counter (saturating 16-bit counter with clear and tick enable), instantiated for gap, delay, wait.

Verification
REQ-032 Bytes at t0, then silence; dly_set_i=100, tx_ready=1 -> start pulse after 35+100 ticks, actual_dly_o=100.
REQ-033 dly_set_i=2000 -> clamped, actual_dly_o=999.
REQ-034 Byte arrives at delay tick 50 -> back to GAP, no start; restart timing from new byte.
REQ-035 tx_ready=0 through delay, asserted 20 ticks later -> start pulse, actual_dly_o=target+20; never asserted -> p_timeout_o=1 after 9999 ticks, IDLE.
REQ-036 n_clr_i low during DELAY -> IDLE next clk, p_busy_o=0, no start; rst low in SEND -> all outputs 0.
REQ-037 dly_set_i=0 -> start pulse one clk after DELAY entry, actual_dly_o=0.

Source files
------------

// File: rtl/ans_delay_generator_pkg.sv
// Shared definitions for the answer-delay generator: FSM state encoding,
// default timing limits and counter slot indices.
package ans_delay_generator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GAP       = 3'd1,
    ST_DELAY     = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_SEND      = 3'd4
  } state_e;

  // Default limits, all expressed in time-base ticks.
  localparam logic [15:0] DEF_GAP_TICKS    = 16'd35;
  localparam logic [15:0] DEF_MAX_DLY_TIME = 16'd999;
  localparam logic [15:0] DEF_MAX_WAIT     = 16'd9999;

  // Saturation ceiling of every 16-bit counter.
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Slot indices of the three tick counters in the top level.
  localparam int CNT_GAP  = 0;
  localparam int CNT_DLY  = 1;
  localparam int CNT_WAIT = 2;
  localparam int NUM_CNT  = 3;

  // Clamp a requested value to an upper limit.
  function automatic logic [15:0] clamp_u16(input logic [15:0] val,
                                            input logic [15:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/ans_delay_generator_tick_counter.sv
// Saturating 16-bit tick counter with synchronous clear.
// Clear has priority over the tick enable; the count sticks at all-ones.
module ans_delay_generator_tick_counter
  import ans_delay_generator_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        tick_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear, saturating increment on tick, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ans_delay_generator.sv
// Answer-delay generator: detects end of a received frame by inter-byte
// silence, waits a programmed (clamped) delay, then commands the tx core
// to start once response data is present, with a watchdog on the data.
module ans_delay_generator
  import ans_delay_generator_pkg::*;
#(
  parameter logic [15:0] GAP_TICKS    = DEF_GAP_TICKS,
  parameter logic [15:0] MAX_DLY_TIME = DEF_MAX_DLY_TIME,
  parameter logic [15:0] MAX_WAIT     = DEF_MAX_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_sig_10MHz_i,
  input  logic        p_DataReceived_i,
  input  logic [15:0] dly_set_i,
  input  logic        p_tx_ready_i,
  input  logic        p_SendFinished_i,
  input  logic        n_clr_i,
  output logic        p_tx_start_o,
  output logic        p_busy_o,
  output logic        p_timeout_o,
  output logic [15:0] actual_dly_o
);

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic        timeout_q, timeout_d;
  logic [15:0] actual_q, actual_d;
  logic [15:0] target_q, target_d;

  logic [NUM_CNT-1:0] cnt_clr;
  logic [NUM_CNT-1:0] cnt_tick;
  logic [15:0]        cnt_val [NUM_CNT];

  logic [15:0] gap_cnt;
  logic [15:0] dly_cnt;
  logic [15:0] wait_cnt;
  logic        gap_done;
  logic        wait_done;

  // Counters are held at zero outside the states that use them, so each
  // starts from zero on entry without an explicit load.
  always_comb begin
    cnt_clr[CNT_GAP]  = !n_clr_i || (state_q != ST_GAP) || p_DataReceived_i;
    cnt_clr[CNT_DLY]  = !n_clr_i ||
                        !((state_q == ST_DELAY) || (state_q == ST_WAIT_DATA));
    cnt_clr[CNT_WAIT] = !n_clr_i || (state_q != ST_WAIT_DATA);
    cnt_tick          = {NUM_CNT{p_sig_10MHz_i}};
  end

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      ans_delay_generator_tick_counter u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr[gi]),
        .tick_i (cnt_tick[gi]),
        .cnt_o  (cnt_val[gi])
      );
    end
  endgenerate

  assign gap_cnt  = cnt_val[CNT_GAP];
  assign dly_cnt  = cnt_val[CNT_DLY];
  assign wait_cnt = cnt_val[CNT_WAIT];

  // The current tick completes the silence / watchdog window (17-bit
  // compare so a zero limit cannot wrap).
  assign gap_done  = ({1'b0, gap_cnt} + 17'd1)  >= {1'b0, GAP_TICKS};
  assign wait_done = ({1'b0, wait_cnt} + 17'd1) >= {1'b0, MAX_WAIT};

  // Next-state, start pulse, timeout flag and delay capture.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    timeout_d = timeout_q;
    actual_d  = actual_q;
    target_d  = target_q;

    case (state_q)
      ST_IDLE: begin
        if (p_DataReceived_i) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // A byte in the same clk as a tick restarts the silence window.
        if (!p_DataReceived_i && p_sig_10MHz_i && gap_done) begin
          state_d  = ST_DELAY;
          target_d = clamp_u16(dly_set_i, MAX_DLY_TIME);
        end
      end
      ST_DELAY: begin
        // A late byte means the frame was not over after all.
        if (p_DataReceived_i) begin
          state_d = ST_GAP;
        end else if (dly_cnt >= target_q) begin
          if (p_tx_ready_i) begin
            start_d  = 1'b1;
            actual_d = dly_cnt;
            state_d  = ST_SEND;
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        // Data arriving in the same clk as the watchdog limit still wins.
        if (p_tx_ready_i) begin
          start_d  = 1'b1;
          actual_d = dly_cnt;
          state_d  = ST_SEND;
        end else if (p_sig_10MHz_i && wait_done) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (p_SendFinished_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort: back to idle with no start; the last measured delay is kept.
    if (!n_clr_i) begin
      state_d   = ST_IDLE;
      start_d   = 1'b0;
      timeout_d = 1'b0;
      actual_d  = actual_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      actual_q  <= '0;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      actual_q  <= actual_d;
      target_q  <= target_d;
    end
  end

  assign p_tx_start_o = start_q;
  assign p_busy_o     = (state_q != ST_IDLE);
  assign p_timeout_o  = timeout_q;
  assign actual_dly_o = actual_q;

endmodule

// File: tb/tb_ans_delay_generator.sv
// Self-checking bench for ans_delay_generator. Expected start timing and
// captured delay are derived from tick counts relative to frame end.
module tb_ans_delay_generator;

  localparam int GAP  = 35;
  localparam int MAXD = 999;
  localparam int MAXW = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        byte_rx = 1'b0;
  logic [15:0] dly_set = '0;
  logic        ready = 1'b0;
  logic        fin = 1'b0;
  logic        n_clr = 1'b1;
  logic        p_tx_start_o;
  logic        p_busy_o;
  logic        p_timeout_o;
  logic [15:0] actual_dly_o;

  int          n_tests = 0;
  int          n_fail = 0;
  int          start_cnt = 0;
  int          last_actual = 0;
  int          exp_last = 0;
  logic        prev_start = 1'b0;

  ans_delay_generator dut (
    .clk              (clk),
    .rst              (rst),
    .p_sig_10MHz_i    (tick),
    .p_DataReceived_i (byte_rx),
    .dly_set_i        (dly_set),
    .p_tx_ready_i     (ready),
    .p_SendFinished_i (fin),
    .n_clr_i          (n_clr),
    .p_tx_start_o     (p_tx_start_o),
    .p_busy_o         (p_busy_o),
    .p_timeout_o      (p_timeout_o),
    .actual_dly_o     (actual_dly_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start-pulse monitor: counts pulses, captures the delay, checks width.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      prev_start = 1'b0;
    end else begin
      if (p_tx_start_o) begin
        start_cnt++;
        last_actual = int'(actual_dly_o);
        check_eq("start_width", {31'd0, prev_start}, 32'd0);
      end
      prev_start = p_tx_start_o;
    end
  end

  // One tick clk followed by 1..2 quiet clks.
  task automatic one_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) one_tick();
  endtask

  task automatic send_byte();
    byte_rx = 1'b1;
    @(negedge clk);
    byte_rx = 1'b0;
  endtask

  task automatic finish_send();
    fin = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    @(negedge clk);
  endtask

  // Frame of nb bytes, programmed delay dly, data ready k ticks after
  // frame end (k==0: ready from the start). Start expected after
  // max(clamped delay, k) ticks past frame end.
  task automatic run_frame(input int dly, input int nb, input int k);
    int base, tgt, exp_act;
    tgt     = (dly > MAXD) ? MAXD : dly;
    exp_act = (k > tgt) ? k : tgt;
    base    = start_cnt;
    dly_set = 16'(dly);
    ready   = (k == 0);
    for (int b = 0; b < nb; b++) begin
      send_byte();
      if (b < nb - 1) ticks($urandom_range(0, GAP - 1));
    end
    ticks(GAP);
    for (int i = 1; i <= exp_act; i++) begin
      if (i == exp_act) check_eq("early_start", start_cnt - base, 0);
      one_tick();
      if (i == k) ready = 1'b1;
    end
    @(negedge clk);
    check_eq("start_count", start_cnt - base, 1);
    check_eq("actual_dly", last_actual, exp_act);
    check_eq("busy_send", {31'd0, p_busy_o}, 1);
    send_byte();                    // ignored while sending
    finish_send();
    check_eq("busy_after_send", {31'd0, p_busy_o}, 0);
    ready    = 1'b0;
    exp_last = exp_act;
    $display("[TB] frame dly=%0d bytes=%0d ready_at=%0d actual=%0d", dly, nb, k, last_actual);
  endtask

  initial begin
    int base, dly, tgt, k;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_start", {31'd0, p_tx_start_o}, 0);
    check_eq("rst_busy", {31'd0, p_busy_o}, 0);
    check_eq("rst_timeout", {31'd0, p_timeout_o}, 0);
    check_eq("rst_actual", {16'd0, actual_dly_o}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic delay, clamp, late data, zero delay
    run_frame(100, 1, 0);
    run_frame(2000, 1, 0);
    run_frame(60, 2, 80);
    run_frame(0, 1, 0);

    // Exact frame-end boundary, and byte colliding with a tick
    base = start_cnt;
    dly_set = 16'd0;
    ready = 1'b1;
    send_byte();
    ticks(GAP - 1);
    check_eq("gap_not_done", start_cnt - base, 0);
    byte_rx = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    byte_rx = 1'b0;
    tick = 1'b0;
    @(negedge clk);
    ticks(GAP - 1);
    check_eq("byte_beats_tick", start_cnt - base, 0);
    one_tick();
    check_eq("zero_dly_start", start_cnt - base, 1);
    check_eq("zero_dly_actual", last_actual, 0);
    finish_send();
    exp_last = 0;
    $display("[TB] gap boundary / byte-vs-tick start_count=%0d", start_cnt - base);

    // Byte during delay restarts the whole timing
    base = start_cnt;
    dly_set = 16'd100;
    send_byte();
    ticks(GAP + 50);
    check_eq("redelay_no_start", start_cnt - base, 0);
    send_byte();
    ticks(GAP + 99);
    check_eq("redelay_early", start_cnt - base, 0);
    one_tick();
    check_eq("redelay_start", start_cnt - base, 1);
    check_eq("redelay_actual", last_actual, 100);
    finish_send();
    exp_last = 100;
    $display("[TB] byte during delay actual=%0d", last_actual);

    // Randomized frames
    for (int n = 0; n < 8; n++) begin
      dly = ($urandom_range(0, 3) == 0) ? $urandom_range(900, 1200) : $urandom_range(0, 150);
      tgt = (dly > MAXD) ? MAXD : dly;
      k   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, tgt) : $urandom_range(tgt + 1, tgt + 40);
      run_frame(dly, $urandom_range(1, 4), k);
    end

    // Watchdog expiry with data never ready
    base = start_cnt;
    dly_set = 16'd5;
    ready = 1'b0;
    send_byte();
    ticks(GAP + 5);
    ticks(MAXW - 1);
    check_eq("timeout_early", {31'd0, p_timeout_o}, 0);
    check_eq("wait_busy", {31'd0, p_busy_o}, 1);
    one_tick();
    check_eq("timeout_set", {31'd0, p_timeout_o}, 1);
    check_eq("timeout_idle", {31'd0, p_busy_o}, 0);
    check_eq("timeout_no_start", start_cnt - base, 0);
    $display("[TB] timeout timeout=%0d busy=%0d", p_timeout_o, p_busy_o);

    // Abort during delay
    dly_set = 16'd500;
    send_byte();
    ticks(GAP + 50);
    check_eq("timeout_sticky", {31'd0, p_timeout_o}, 1);
    n_clr = 1'b0;
    @(negedge clk);
    n_clr = 1'b1;
    check_eq("clr_busy", {31'd0, p_busy_o}, 0);
    check_eq("clr_timeout", {31'd0, p_timeout_o}, 0);
    check_eq("clr_actual_kept", {16'd0, actual_dly_o}, exp_last);
    ready = 1'b1;
    ticks(520);
    check_eq("clr_no_start", start_cnt - base, 0);
    check_eq("clr_stay_idle", {31'd0, p_busy_o}, 0);
    $display("[TB] abort busy=%0d start_count=%0d", p_busy_o, start_cnt - base);

    // Reset while sending
    base = start_cnt;
    dly_set = 16'd0;
    send_byte();
    ticks(GAP);
    check_eq("pre_rst_start", start_cnt - base, 1);
    check_eq("pre_rst_busy", {31'd0, p_busy_o}, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_send_start", {31'd0, p_tx_start_o}, 0);
    check_eq("rst_send_busy", {31'd0, p_busy_o}, 0);
    check_eq("rst_send_timeout", {31'd0, p_timeout_o}, 0);
    check_eq("rst_send_actual", {16'd0, actual_dly_o}, 0);
    @(negedge clk);
    rst = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset in send busy=%0d actual=%0d", p_busy_o, actual_dly_o);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
